hybrid_buffer_slot_scheduler: RTL and testbench

- Controller for a NUM_SLOTS hybrid buffer (RAM-style write side, FIFO-style read side).
- Allocates free slots to upstream node requests and programs each slot's node ID.
- Tracks each slot's lifecycle.
- Round-robin drains completed slots, one at a time, onto a single valid/ready stream to the downstream engine.

---
 rtl/hybrid_buffer_sched_pkg.sv | 23 ++
 rtl/hybrid_buffer_rr_arbiter.sv | 31 +++
 rtl/hybrid_buffer_slot_scheduler.sv | 178 +++++++++++++++++
 tb/tb_hybrid_buffer_slot_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_buffer_sched_pkg.sv
// Shared types and default widths for the hybrid buffer slot scheduler.
package hybrid_buffer_sched_pkg;

  localparam int unsigned DefNumSlots    = 16;
  localparam int unsigned DefReadWidth   = 32;
  localparam int unsigned DefReadDepth   = 1024;
  localparam int unsigned DefSlotIdWidth = 20;
  localparam int unsigned DefSlotIdxWidth = $clog2(DefNumSlots);
  localparam int unsigned DefCountWidth   = $clog2(DefReadDepth);

  typedef enum logic [1:0] {
    SlotFree,
    SlotAllocated,
    SlotReady,
    SlotDraining
  } slot_state_t;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } drain_state_t;

endpackage

// File: rtl/hybrid_buffer_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr+1, wrapping.
module hybrid_buffer_rr_arbiter
  import hybrid_buffer_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DefNumSlots,
  localparam int unsigned IdxW = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [IdxW-1:0]      ptr,
  output logic [NUM_SLOTS-1:0] grant,
  output logic [IdxW-1:0]      idx,
  output logic                 any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 1; k <= int'(NUM_SLOTS); k++) begin
      j = (int'(ptr) + k) % int'(NUM_SLOTS);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/hybrid_buffer_slot_scheduler.sv
// Slot allocator and round-robin drain controller for the hybrid buffer.
// Optional stall counters are enabled with HYBRID_BUFFER_SCHED_PERF_EN.
module hybrid_buffer_slot_scheduler
  import hybrid_buffer_sched_pkg::*;
#(
  parameter int unsigned NUM_SLOTS     = DefNumSlots,
  parameter int unsigned READ_WIDTH    = DefReadWidth,
  parameter int unsigned READ_DEPTH    = DefReadDepth,
  parameter int unsigned SLOT_ID_WIDTH = DefSlotIdWidth,
  localparam int unsigned IdxW = $clog2(NUM_SLOTS),
  localparam int unsigned CntW = $clog2(READ_DEPTH)
) (
`ifdef HYBRID_BUFFER_SCHED_PERF_EN
  output logic [31:0]                        perf_alloc_stall,
  output logic [31:0]                        perf_drain_stall,
`endif
  input  logic                               core_clk,
  input  logic                               resetn,
  input  logic                               alloc_req_valid,
  output logic                               alloc_req_ready,
  input  logic [SLOT_ID_WIDTH-1:0]           alloc_req_node_id,
  output logic [IdxW-1:0]                    alloc_slot,
  output logic [NUM_SLOTS-1:0]               set_node_id_valid,
  output logic [NUM_SLOTS*SLOT_ID_WIDTH-1:0] set_node_id,
  input  logic [NUM_SLOTS-1:0]               write_done,
  input  logic [NUM_SLOTS-1:0]               slot_free,
  input  logic [NUM_SLOTS*CntW-1:0]          feature_count,
  input  logic [NUM_SLOTS-1:0]               out_feature_valid,
  input  logic [NUM_SLOTS*READ_WIDTH-1:0]    out_feature,
  output logic [NUM_SLOTS-1:0]               pop,
  output logic                               drain_valid,
  input  logic                               drain_ready,
  output logic [READ_WIDTH-1:0]              drain_data,
  output logic [SLOT_ID_WIDTH-1:0]           drain_node_id,
  output logic                               drain_last
);

  slot_state_t              slot_q [NUM_SLOTS];
  slot_state_t              slot_d [NUM_SLOTS];
  logic [SLOT_ID_WIDTH-1:0] id_q   [NUM_SLOTS];
  logic [SLOT_ID_WIDTH-1:0] id_d   [NUM_SLOTS];

  drain_state_t             st_q, st_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [IdxW-1:0]          dslot_q, dslot_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [CntW-1:0]          beat_q, beat_d;
  logic [SLOT_ID_WIDTH-1:0] did_q, did_d;

  logic [NUM_SLOTS-1:0] alloc_mask, alloc_onehot, ready_mask, rr_grant;
  logic [IdxW-1:0]      alloc_idx, rr_idx;
  logic                 rr_any, alloc_fire, drain_fire, in_drain;

  always_comb begin
    alloc_mask = '0;
    ready_mask = '0;
    alloc_idx  = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      alloc_mask[i] = (slot_q[i] == SlotFree) && slot_free[i];
      ready_mask[i] = (slot_q[i] == SlotReady);
    end
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (alloc_mask[i]) alloc_idx = IdxW'(i);
    end
  end

  assign alloc_onehot    = alloc_mask & (~alloc_mask + NUM_SLOTS'(1));
  assign alloc_req_ready = |alloc_mask;
  // Gated by resetn so the write strobe drops immediately on reset assertion.
  assign alloc_fire        = alloc_req_valid & alloc_req_ready & resetn;
  assign alloc_slot        = alloc_fire ? alloc_idx : '0;
  assign set_node_id_valid = alloc_fire ? alloc_onehot : '0;
  assign set_node_id       = alloc_fire ? {NUM_SLOTS{alloc_req_node_id}} : '0;

  hybrid_buffer_rr_arbiter #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_rr_arbiter (
    .req   (ready_mask),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign in_drain      = (st_q == StDrain);
  assign drain_valid   = in_drain & out_feature_valid[dslot_q];
  assign drain_data    = in_drain ? out_feature[dslot_q*READ_WIDTH +: READ_WIDTH] : '0;
  assign drain_node_id = in_drain ? did_q : '0;
  assign drain_last    = in_drain & (beat_q == cnt_q - CntW'(1));
  assign drain_fire    = drain_valid & drain_ready;
  assign pop           = drain_fire ? (NUM_SLOTS'(1) << dslot_q) : '0;

  always_comb begin
    slot_d  = slot_q;
    id_d    = id_q;
    st_d    = st_q;
    ptr_d   = ptr_q;
    dslot_d = dslot_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    did_d   = did_q;

    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (alloc_fire && alloc_onehot[i]) begin
        slot_d[i] = SlotAllocated;
        id_d[i]   = alloc_req_node_id;
      end
      if (write_done[i] && slot_q[i] == SlotAllocated) slot_d[i] = SlotReady;
    end

    unique case (st_q)
      StIdle: begin
        if (rr_any) begin
          dslot_d = rr_idx;
          cnt_d   = feature_count[rr_idx*CntW +: CntW];
          did_d   = id_q[rr_idx];
          beat_d  = '0;
          // An empty slot is retired on the spot without issuing any beat.
          for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (rr_grant[i]) slot_d[i] = (cnt_d == '0) ? SlotFree : SlotDraining;
          end
          if (cnt_d == '0) ptr_d = rr_idx;
          else             st_d  = StDrain;
        end
      end
      StDrain: begin
        if (drain_fire) begin
          beat_d = beat_q + CntW'(1);
          if (drain_last) begin
            slot_d[dslot_q] = SlotFree;
            ptr_d           = dslot_q;
            st_d            = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        slot_q[i] <= SlotFree;
        id_q[i]   <= '0;
      end
      st_q    <= StIdle;
      ptr_q   <= '0;
      dslot_q <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      did_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      id_q    <= id_d;
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      dslot_q <= dslot_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      did_q   <= did_d;
    end
  end

`ifdef HYBRID_BUFFER_SCHED_PERF_EN
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      perf_alloc_stall <= '0;
      perf_drain_stall <= '0;
    end else begin
      if (alloc_req_valid && !alloc_req_ready && perf_alloc_stall != '1)
        perf_alloc_stall <= perf_alloc_stall + 32'd1;
      if (drain_valid && !drain_ready && perf_drain_stall != '1)
        perf_drain_stall <= perf_drain_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hybrid_buffer_slot_scheduler.sv
// Directed self-checking bench for hybrid_buffer_slot_scheduler.
module tb_hybrid_buffer_slot_scheduler;

  localparam int N  = 16;
  localparam int RW = 32;
  localparam int CW = 10;
  localparam int IW = 20;

  logic              core_clk = 1'b0;
  logic              resetn   = 1'b0;
  logic              alloc_req_valid;
  logic              alloc_req_ready;
  logic [IW-1:0]     alloc_req_node_id;
  logic [3:0]        alloc_slot;
  logic [N-1:0]      set_node_id_valid;
  logic [N*IW-1:0]   set_node_id;
  logic [N-1:0]      write_done;
  logic [N-1:0]      slot_free;
  logic [N*CW-1:0]   feature_count;
  logic [N-1:0]      out_feature_valid;
  logic [N*RW-1:0]   out_feature;
  logic [N-1:0]      pop;
  logic              drain_valid;
  logic              drain_ready;
  logic [RW-1:0]     drain_data;
  logic [IW-1:0]     drain_node_id;
  logic              drain_last;
`ifdef HYBRID_BUFFER_SCHED_PERF_EN
  logic [31:0]       perf_alloc_stall;
  logic [31:0]       perf_drain_stall;
`endif

  logic [CW-1:0] fc     [N];
  int            rd     [N];
  int            exp_rd [N];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 core_clk = ~core_clk;

  hybrid_buffer_slot_scheduler dut (
`ifdef HYBRID_BUFFER_SCHED_PERF_EN
    .perf_alloc_stall  (perf_alloc_stall),
    .perf_drain_stall  (perf_drain_stall),
`endif
    .core_clk          (core_clk),
    .resetn            (resetn),
    .alloc_req_valid   (alloc_req_valid),
    .alloc_req_ready   (alloc_req_ready),
    .alloc_req_node_id (alloc_req_node_id),
    .alloc_slot        (alloc_slot),
    .set_node_id_valid (set_node_id_valid),
    .set_node_id       (set_node_id),
    .write_done        (write_done),
    .slot_free         (slot_free),
    .feature_count     (feature_count),
    .out_feature_valid (out_feature_valid),
    .out_feature       (out_feature),
    .pop               (pop),
    .drain_valid       (drain_valid),
    .drain_ready       (drain_ready),
    .drain_data        (drain_data),
    .drain_node_id     (drain_node_id),
    .drain_last        (drain_last)
  );

  function automatic logic [RW-1:0] word(input int s, input int n);
    return {8'hA5, 4'(s), 20'(n)};
  endfunction

  // Buffer model: each slot presents its next word until popped.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feature_count[i*CW +: CW] = fc[i];
      out_feature[i*RW +: RW]   = word(i, rd[i]);
    end
  end

  always @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) rd[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) if (pop[i]) rd[i] <= rd[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge core_clk);
    #1;
  endtask

  task automatic wait_valid();
    int waited = 0;
    while (drain_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    check("wait_drain_valid", 64'(drain_valid), 64'd1);
  endtask

  task automatic beat(input int s, input logic [IW-1:0] id, input logic last);
    check("drain_valid", 64'(drain_valid), 64'd1);
    check("drain_pop", 64'(pop), 64'(1) << s);
    check("drain_node_id", 64'(drain_node_id), 64'(id));
    check("drain_data", 64'(drain_data), 64'(word(s, exp_rd[s])));
    check("drain_last", 64'(drain_last), 64'(last));
    exp_rd[s]++;
    tick();
  endtask

  task automatic drain_slot(input int s, input logic [IW-1:0] id, input int cnt);
    drain_ready = 1'b1;
    #1;
    wait_valid();
    for (int b = 0; b < cnt; b++) beat(s, id, b == cnt - 1);
  endtask

  initial begin
    int n;
    alloc_req_valid   = 1'b0;
    alloc_req_node_id = '0;
    write_done        = '0;
    slot_free         = '1;
    out_feature_valid = '1;
    drain_ready       = 1'b0;
    for (int i = 0; i < N; i++) begin
      fc[i]     = '0;
      exp_rd[i] = 0;
    end
    #1;
    check("rst_alloc_ready", 64'(alloc_req_ready), 64'd1);
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_drain_valid", 64'(drain_valid), 64'd0);
    check("rst_set_valid", 64'(set_node_id_valid), 64'd0);
    check("rst_drain_last", 64'(drain_last), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Three allocations land on slots 0, 1, 2.
    for (int k = 0; k < 3; k++) begin
      alloc_req_valid   = 1'b1;
      alloc_req_node_id = IW'(32'h10 + k);
      #1;
      check("alloc_slot", 64'(alloc_slot), 64'(k));
      check("alloc_set_valid", 64'(set_node_id_valid), 64'(1) << k);
      check("alloc_set_id", 64'(set_node_id[k*IW +: IW]), 64'(32'h10 + k));
      tick();
    end
    alloc_req_valid = 1'b0;

    // Slot 1 with four features.
    fc[1]      = 10'd4;
    write_done = 16'h0002;
    tick();
    write_done = '0;
    #1;
    check("grant_latency", 64'(drain_valid), 64'd0);
    drain_slot(1, 20'h11, 4);
    check("s1_idle_after", 64'(drain_valid), 64'd0);

    // Slot 1 is free again; reallocate it, then take 3, 4, 5.
    alloc_req_valid   = 1'b1;
    alloc_req_node_id = 20'h21;
    #1;
    check("realloc_slot1", 64'(alloc_slot), 64'd1);
    tick();
    for (int k = 3; k < 6; k++) begin
      alloc_req_node_id = IW'(32'h10 + k);
      #1;
      check("alloc_slot", 64'(alloc_slot), 64'(k));
      tick();
    end
    alloc_req_valid = 1'b0;

    // Slots 0, 2, 5 ready together; ptr is 1 so order is 2, 5, 0.
    fc[0]      = 10'd2;
    fc[2]      = 10'd1;
    fc[5]      = 10'd3;
    write_done = 16'h0025;
    tick();
    write_done = '0;
    drain_slot(2, 20'h12, 1);
    drain_slot(5, 20'h15, 3);
    drain_slot(0, 20'h10, 2);

    // write_done on a FREE slot must not change its state.
    slot_free  = 16'h0040;
    write_done = 16'h0040;
    tick();
    write_done = '0;
    tick();
    check("wd_ignored_free", 64'(alloc_req_ready), 64'd1);
    slot_free = '1;

    // Backpressure on slot 1: ready 1, 0, 0, 1...
    fc[1]       = 10'd4;
    write_done  = 16'h0002;
    tick();
    write_done  = '0;
    drain_ready = 1'b1;
    #1;
    wait_valid();
    beat(1, 20'h21, 1'b0);
    drain_ready = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("bp_pop", 64'(pop), 64'd0);
      check("bp_valid", 64'(drain_valid), 64'd1);
      check("bp_data", 64'(drain_data), 64'(word(1, exp_rd[1])));
      check("bp_node_id", 64'(drain_node_id), 64'h21);
      tick();
    end
    drain_ready = 1'b1;
    #1;
    for (int b = 1; b < 4; b++) beat(1, 20'h21, b == 3);
    check("bp_total_beats", 64'(drain_valid), 64'd0);
    check("bp_buffer_pops", 64'(rd[1]), 64'd8);
`ifdef HYBRID_BUFFER_SCHED_PERF_EN
    check("perf_drain_stall", 64'(perf_drain_stall), 64'd2);
`endif

    // Zero-feature slot 3: never drives a beat, FREE two cycles after write_done.
    fc[3]      = 10'd0;
    slot_free  = 16'h0008;
    write_done = 16'h0008;
    #1;
    check("zc_alloc_state", 64'(alloc_req_ready), 64'd0);
    tick();
    write_done = '0;
    #1;
    check("zc_ready_state", 64'(alloc_req_ready), 64'd0);
    check("zc_no_valid0", 64'(drain_valid), 64'd0);
    tick();
    check("zc_freed", 64'(alloc_req_ready), 64'd1);
    check("zc_no_valid1", 64'(drain_valid), 64'd0);
    slot_free = '1;

    // Fill the remaining 15 slots, then stall for five cycles.
    alloc_req_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && alloc_req_ready; k++) begin
      alloc_req_node_id = IW'(32'h100 + k);
      tick();
      n++;
    end
    check("fill_count", 64'(n), 64'd15);
    check("full_ready", 64'(alloc_req_ready), 64'd0);
    repeat (5) begin
      check("full_no_strobe", 64'(set_node_id_valid), 64'd0);
      tick();
    end
    alloc_req_valid = 1'b0;
`ifdef HYBRID_BUFFER_SCHED_PERF_EN
    check("perf_alloc_stall", 64'(perf_alloc_stall), 64'd5);
`endif

    // Slot 7 (node 0x106) drains; reset hits after one beat.
    fc[7]       = 10'd5;
    write_done  = 16'h0080;
    tick();
    write_done  = '0;
    drain_ready = 1'b1;
    #1;
    wait_valid();
    check("rst_mid_node_id", 64'(drain_node_id), 64'h106);
    tick();
    check("rst_mid_active", 64'(pop), 64'h80);
    resetn = 1'b0;
    #1;
    check("rst_mid_pop", 64'(pop), 64'd0);
    check("rst_mid_valid", 64'(drain_valid), 64'd0);
    check("rst_mid_node", 64'(drain_node_id), 64'd0);
    tick();
    resetn    = 1'b1;
    slot_free = 16'h8000;
    #1;
    check("rst_slot15_free", 64'(alloc_req_ready), 64'd1);
`ifdef HYBRID_BUFFER_SCHED_PERF_EN
    check("rst_perf_alloc", 64'(perf_alloc_stall), 64'd0);
    check("rst_perf_drain", 64'(perf_drain_stall), 64'd0);
`endif
    tick();
    tick();
    check("rst_no_drain", 64'(drain_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
